instr_fetch_unit: RTL

Instruction fetch stage of the RISC-V single-cycle core. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a req/ready handshake, and presents it with its opcode field to the main decoder. On each retire it computes the next PC from the decoder's `branch`/`jump` outputs and the ALU zero flag. It traps misaligned control-flow targets.

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ready fetch handshake, next-PC selection and misaligned-target trap.
// Optional retire counter built when INSTR_FETCH_PERF_CNT_EN is defined; otherwise retire_count is tied to zero.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] pc_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err,
    output logic [31:0] retire_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   instr_q;
    logic              req_q;
    logic              valid_q;
    logic              err_q;

    logic              retire_ok;
    logic              taken;
    logic              target_misaligned;
    logic [XLEN-1:0]   pc_d;

    assign pc_plus4          = pc_q + XLEN'(4);
    assign retire_ok         = (state_q == VALID) && retire;
    assign taken             = jump | (branch & zero);
    assign target_misaligned = taken && (pc_target[1:0] != 2'b00);
    assign pc_d              = taken ? pc_target : pc_plus4;

    // Fetch FSM; outputs are registered alongside the state so reset clears them asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        state_q <= VALID;
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (retire) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        if (target_misaligned) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [XLEN-1:0] retire_cnt_q;

    // Counts every honoured retire, including one that traps on a misaligned target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (retire_ok) begin
            retire_cnt_q <= retire_cnt_q + XLEN'(1);
        end
    end

    assign retire_count = retire_cnt_q;
`else
    logic unused_retire_ok;
    assign unused_retire_ok = retire_ok;
    assign retire_count     = '0;
`endif

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[6:0];
    assign instr_valid  = valid_q;
    assign misalign_err = err_q;

endmodule
